halli_galli_ctrl: RTL and testbench

HALLI_GALLI_CTRL -- requirements
Module: halli_galli_ctrl

---
 rtl/halli_galli_ctrl.sv | 168 ++++++++++++++++
 tb/tb_halli_galli_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halli_galli_ctrl.sv
// Halli Galli table controller: turn order, card fetching, bell judging and scoring.
// The random card source is a plain card_req / card_valid handshake, described below.
module halli_galli_ctrl #(
  parameter int N_PLAYERS = 2,
  parameter int TARGET    = 5,
  parameter int SCORE_W   = 9,
  parameter int WIN_SCORE = 100,
  parameter int PENALTY   = 2,
  parameter int TIMEOUT   = 0,
  localparam int PW       = $clog2(N_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         flip,
  input  logic [N_PLAYERS-1:0]         bell,
  output logic                         card_req,
  input  logic                         card_valid,
  input  logic [4:0]                   card_in,
  output logic [5*N_PLAYERS-1:0]       top_card,
  output logic [N_PLAYERS-1:0]         top_valid,
  output logic [PW-1:0]                turn,
  output logic [SCORE_W*N_PLAYERS-1:0] score,
  output logic [7:0]                   pile_cnt,
  output logic                         game_over,
  output logic [PW-1:0]                winner,
  output logic                         bell_ok,
  output logic                         bell_bad,
  output logic [2:0]                   fsm_state
);

  typedef enum logic [2:0] {IDLE, WAIT, FETCH, JUDGE, OVER} state_t;

  localparam int AW = ((SCORE_W > 8) ? SCORE_W : 8) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t        state;
  logic [PW-1:0] ringer;
  logic [15:0]   tmo_cnt;

  logic [5:0]         col_sum [4];
  logic               hit;
  logic [PW-1:0]      ringer_next;
  logic [PW-1:0]      next_turn;
  logic [SCORE_W-1:0] cur_score;
  logic [AW-1:0]      add_ext;
  logic [SCORE_W-1:0] new_score;
  logic               win;
  logic               tmo_hit;

  // Handshake: card_req is high for the whole FETCH state; a card is taken on
  // the first rising edge where card_req and card_valid are both high.
  assign card_req  = (state == FETCH);
  assign fsm_state = state;

  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      col_sum[c] = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (top_valid[p] && (top_card[5*p+3 +: 2] == 2'(c)) &&
            (top_card[5*p +: 3] >= 3'd1) && (top_card[5*p +: 3] <= 3'd5))
          col_sum[c] = col_sum[c] + 6'(top_card[5*p +: 3]);
      end
      if (col_sum[c] == 6'(TARGET)) hit = 1'b1;
    end

    // Scan downward so the lowest pressed index wins.
    ringer_next = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (bell[p]) ringer_next = PW'(p);
    end

    next_turn = (turn == PW'(N_PLAYERS - 1)) ? '0 : turn + PW'(1);

    cur_score = score[SCORE_W*ringer +: SCORE_W];
    add_ext   = AW'(cur_score) + AW'(pile_cnt);
    if (hit)
      new_score = (add_ext > AW'(SCORE_MAX)) ? SCORE_MAX : add_ext[SCORE_W-1:0];
    else if (int'(cur_score) < PENALTY)
      new_score = '0;
    else
      new_score = cur_score - SCORE_W'(PENALTY);
    win = (int'(new_score) >= WIN_SCORE);

    tmo_hit = (TIMEOUT > 0) && (int'(tmo_cnt) == TIMEOUT - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      turn      <= '0;
      winner    <= '0;
      ringer    <= '0;
      score     <= '0;
      top_card  <= '0;
      top_valid <= '0;
      pile_cnt  <= '0;
      game_over <= 1'b0;
      bell_ok   <= 1'b0;
      bell_bad  <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      bell_ok  <= 1'b0;
      bell_bad <= 1'b0;
      if (start) begin
        // A restart from any state abandons whatever was in flight.
        state     <= WAIT;
        score     <= '0;
        top_valid <= '0;
        pile_cnt  <= '0;
        turn      <= '0;
        game_over <= 1'b0;
        tmo_cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          WAIT: begin
            if (|bell) begin
              ringer  <= ringer_next;
              state   <= JUDGE;
              tmo_cnt <= '0;
            end else if (flip[turn]) begin
              state   <= FETCH;
              tmo_cnt <= '0;
            end else if (TIMEOUT > 0) begin
              if (tmo_hit) begin
                turn    <= next_turn;
                tmo_cnt <= '0;
              end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
              end
            end
          end
          FETCH: begin
            if (card_valid) begin
              top_card[5*turn +: 5] <= card_in;
              top_valid[turn]       <= 1'b1;
              if (pile_cnt != 8'hFF) pile_cnt <= pile_cnt + 8'd1;
              turn  <= next_turn;
              state <= WAIT;
            end
          end
          JUDGE: begin
            score[SCORE_W*ringer +: SCORE_W] <= new_score;
            if (hit) begin
              bell_ok   <= 1'b1;
              top_valid <= '0;
              pile_cnt  <= '0;
            end else begin
              bell_bad <= 1'b1;
            end
            if (win) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= ringer;
            end else begin
              state <= WAIT;
            end
          end
          OVER:    state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_halli_galli_ctrl.sv
// Directed bench for halli_galli_ctrl: instance a uses defaults, instance b has
// WIN_SCORE=3 and TIMEOUT=10. Both share stimulus; each scenario starts with start.
module tb_halli_galli_ctrl;

  localparam int S_IDLE = 0, S_WAIT = 1, S_FETCH = 2, S_JUDGE = 3, S_OVER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] flip = '0;
  logic [1:0] bell = '0;
  logic       card_valid = 1'b0;
  logic [4:0] card_in = '0;

  logic        a_card_req, a_game_over, a_bell_ok, a_bell_bad;
  logic [9:0]  a_top_card;
  logic [1:0]  a_top_valid;
  logic [0:0]  a_turn, a_winner;
  logic [17:0] a_score;
  logic [7:0]  a_pile_cnt;
  logic [2:0]  a_state;

  logic        b_card_req, b_game_over, b_bell_ok, b_bell_bad;
  logic [9:0]  b_top_card;
  logic [1:0]  b_top_valid;
  logic [0:0]  b_turn, b_winner;
  logic [17:0] b_score;
  logic [7:0]  b_pile_cnt;
  logic [2:0]  b_state;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  halli_galli_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .flip(flip), .bell(bell),
    .card_req(a_card_req), .card_valid(card_valid), .card_in(card_in),
    .top_card(a_top_card), .top_valid(a_top_valid), .turn(a_turn),
    .score(a_score), .pile_cnt(a_pile_cnt), .game_over(a_game_over),
    .winner(a_winner), .bell_ok(a_bell_ok), .bell_bad(a_bell_bad),
    .fsm_state(a_state)
  );

  halli_galli_ctrl #(.WIN_SCORE(3), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst(rst), .start(start), .flip(flip), .bell(bell),
    .card_req(b_card_req), .card_valid(card_valid), .card_in(card_in),
    .top_card(b_top_card), .top_valid(b_top_valid), .turn(b_turn),
    .score(b_score), .pile_cnt(b_pile_cnt), .game_over(b_game_over),
    .winner(b_winner), .bell_ok(b_bell_ok), .bell_bad(b_bell_bad),
    .fsm_state(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic flip_card(input int p, input logic [4:0] c);
    flip = '0;
    flip[p] = 1'b1;
    tick();
    flip = '0;
    check("a_card_req_fetch", 32'(a_card_req), 1);
    check("b_card_req_fetch", 32'(b_card_req), 1);
    card_in = c;
    card_valid = 1'b1;
    tick();
    card_valid = 1'b0;
  endtask

  task automatic ring(input logic [1:0] m);
    bell = m;
    tick();
    bell = '0;
    tick();
  endtask

  initial begin
    // reset
    #2;
    check("rst_state", 32'(a_state), S_IDLE);
    check("rst_card_req", 32'(a_card_req), 0);
    check("rst_score", 32'(a_score), 0);
    check("rst_pile", 32'(a_pile_cnt), 0);
    check("rst_turn", 32'(a_turn), 0);
    tick();
    rst = 1'b1;
    tick();

    // correct bell by p1 collects the pile
    pulse_start();
    check("s1_state", 32'(a_state), S_WAIT);
    flip_card(0, 5'b01_010);
    check("s1_turn1", 32'(a_turn), 1);
    check("s1_pile1", 32'(a_pile_cnt), 1);
    check("s1_tv1", 32'(a_top_valid), 2'b01);
    flip_card(1, 5'b01_011);
    check("s1_turn0", 32'(a_turn), 0);
    check("s1_top", 32'(a_top_card), 10'b01011_01010);
    check("s1_pile2", 32'(a_pile_cnt), 2);
    ring(2'b10);
    check("s1_bell_ok", 32'(a_bell_ok), 1);
    check("s1_score1", 32'(a_score[17:9]), 2);
    check("s1_pile0", 32'(a_pile_cnt), 0);
    check("s1_tv0", 32'(a_top_valid), 0);
    check("s1_turn_kept", 32'(a_turn), 0);
    tick();
    check("s1_ok_pulse", 32'(a_bell_ok), 0);

    // wrong bells: saturation at zero, then 4 -> 2
    pulse_start();
    flip_card(0, 5'b01_010);
    flip_card(1, 5'b10_011);
    ring(2'b01);
    check("s2_bell_bad", 32'(a_bell_bad), 1);
    check("s2_bell_ok", 32'(a_bell_ok), 0);
    check("s2_score0_sat", 32'(a_score[8:0]), 0);
    check("s2_state", 32'(a_state), S_WAIT);
    flip_card(0, 5'b11_001);
    flip_card(1, 5'b11_100);
    check("s2_pile4", 32'(a_pile_cnt), 4);
    ring(2'b01);
    check("s2_score0_4", 32'(a_score[8:0]), 4);
    ring(2'b01);
    check("s2_bad2", 32'(a_bell_bad), 1);
    check("s2_score0_2", 32'(a_score[8:0]), 2);

    // out-of-turn flip ignored; simultaneous bells credit p0 only
    pulse_start();
    flip = 2'b10;
    tick();
    flip = '0;
    check("s3_no_req", 32'(a_card_req), 0);
    check("s3_state", 32'(a_state), S_WAIT);
    check("s3_turn", 32'(a_turn), 0);
    flip_card(0, 5'b00_010);
    flip_card(1, 5'b00_011);
    ring(2'b11);
    check("s3_ok", 32'(a_bell_ok), 1);
    check("s3_score0", 32'(a_score[8:0]), 2);
    check("s3_score1", 32'(a_score[17:9]), 0);

    // winning on instance b (WIN_SCORE=3)
    pulse_start();
    flip_card(0, 5'b01_010);
    flip_card(1, 5'b01_011);
    ring(2'b01);
    check("s4_score0_2", 32'(b_score[8:0]), 2);
    check("s4_not_over", 32'(b_game_over), 0);
    flip_card(0, 5'b10_001);
    flip_card(1, 5'b10_100);
    check("s4_pile2", 32'(b_pile_cnt), 2);
    ring(2'b01);
    check("s4_score0_4", 32'(b_score[8:0]), 4);
    check("s4_over", 32'(b_game_over), 1);
    check("s4_winner", 32'(b_winner), 0);
    check("s4_state", 32'(b_state), S_OVER);
    flip = 2'b01;
    tick();
    flip = '0;
    bell = 2'b11;
    tick();
    bell = '0;
    tick();
    check("s4_hold_score", 32'(b_score), 18'd4);
    check("s4_hold_state", 32'(b_state), S_OVER);
    check("s4_hold_req", 32'(b_card_req), 0);
    check("s4_hold_ok", 32'(b_bell_ok), 0);
    pulse_start();
    check("s4_restart_state", 32'(b_state), S_WAIT);
    check("s4_restart_score", 32'(b_score), 0);
    check("s4_restart_over", 32'(b_game_over), 0);

    // timeout on instance b (TIMEOUT=10)
    pulse_start();
    for (int i = 0; i < 9; i++) tick();
    check("s5_turn_before", 32'(b_turn), 0);
    tick();
    check("s5_turn_after", 32'(b_turn), 1);
    check("s5_state", 32'(b_state), S_WAIT);
    for (int i = 0; i < 9; i++) tick();
    bell = 2'b01;
    tick();
    bell = '0;
    check("s5_judge", 32'(b_state), S_JUDGE);
    check("s5_turn_kept", 32'(b_turn), 1);
    tick();
    check("s5_bad", 32'(b_bell_bad), 1);
    check("s5_turn_final", 32'(b_turn), 1);

    // asynchronous reset during FETCH with card_valid high
    pulse_start();
    flip_card(0, 5'b01_010);
    flip = 2'b10;
    tick();
    flip = '0;
    check("s6_fetch", 32'(a_state), S_FETCH);
    card_in = 5'b11_111;
    card_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("s6_req_drop", 32'(a_card_req), 0);
    check("s6_state", 32'(a_state), S_IDLE);
    check("s6_pile", 32'(a_pile_cnt), 0);
    check("s6_tv", 32'(a_top_valid), 0);
    check("s6_top", 32'(a_top_card), 0);
    check("s6_turn", 32'(a_turn), 0);
    tick();
    check("s6_hold_state", 32'(a_state), S_IDLE);
    check("s6_hold_tv", 32'(a_top_valid), 0);
    rst = 1'b1;
    card_valid = 1'b0;
    tick();
    check("s6_idle", 32'(a_state), S_IDLE);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
